// File: rtl/seq_divider.sv
// Iterative restoring divider producing one quotient bit per clock, with trial subtraction done by add_sub.
// Optional two's-complement operation is enabled by defining DIV_SIGNED_EN.

module add_sub #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] sum_o,
    output logic         carry_o
);

    // c_i=1 selects a - b; carry_o=1 then means no borrow (a >= b)
    assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i ^ {W{c_i}}} + {{W{1'b0}}, c_i};

endmodule

module seq_divider #(
    parameter int n = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [n-1:0] dividend_i,
    input  logic [n-1:0] divisor_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [n-1:0] quotient_o,
    output logic [n-1:0] remainder_o,
    output logic         div_zero_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state_q, state_d;
    logic [n-1:0]   quo_q, quo_d;
    logic [n-1:0]   rem_q, rem_d;
    logic [n-1:0]   dsr_q, dsr_d;
    logic [3:0]     count_q, count_d;
    logic [n-1:0]   quotient_q, quotient_d;
    logic [n-1:0]   remainder_q, remainder_d;
    logic           divZero_q, divZero_d;

    logic [n-1:0]   magDividend, magDivisor;
    logic [n-1:0]   divZeroQuo;
    logic           r9;
    logic [n-1:0]   rs;
    logic [n-1:0]   trial;
    logic           carry;
    logic [n-1:0]   quoNext, remNext;

`ifdef DIV_SIGNED_EN
    logic negQuo_q, negQuo_d;
    logic negRem_q, negRem_d;

    assign magDividend = dividend_i[n-1] ? -dividend_i : dividend_i;
    assign magDivisor  = divisor_i[n-1]  ? -divisor_i  : divisor_i;
    assign divZeroQuo  = dividend_i[n-1] ? {{(n-1){1'b0}}, 1'b1} : {n{1'b1}};
`else
    assign magDividend = dividend_i;
    assign magDivisor  = divisor_i;
    assign divZeroQuo  = {n{1'b1}};
`endif

    assign {r9, rs} = {rem_q, quo_q[n-1]};

    add_sub #(.W(n)) u_trialSub (
        .a_i     (rs),
        .b_i     (dsr_q),
        .c_i     (1'b1),
        .sum_o   (trial),
        .carry_o (carry)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            quo_q       <= '0;
            rem_q       <= '0;
            dsr_q       <= '0;
            count_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            divZero_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
            negQuo_q    <= 1'b0;
            negRem_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            dsr_q       <= dsr_d;
            count_q     <= count_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            divZero_q   <= divZero_d;
`ifdef DIV_SIGNED_EN
            negQuo_q    <= negQuo_d;
            negRem_q    <= negRem_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        dsr_d       = dsr_q;
        count_d     = count_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        divZero_d   = divZero_q;
`ifdef DIV_SIGNED_EN
        negQuo_d    = negQuo_q;
        negRem_d    = negRem_q;
`endif
        // r9 set means the shifted partial remainder already exceeds any divisor
        if (r9 | carry) begin
            remNext = trial;
            quoNext = {quo_q[n-2:0], 1'b1};
        end else begin
            remNext = rs;
            quoNext = {quo_q[n-2:0], 1'b0};
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (divisor_i != '0) begin
                        state_d   = CALC;
                        quo_d     = magDividend;
                        rem_d     = '0;
                        dsr_d     = magDivisor;
                        count_d   = '0;
                        divZero_d = 1'b0;
`ifdef DIV_SIGNED_EN
                        negQuo_d  = dividend_i[n-1] ^ divisor_i[n-1];
                        negRem_d  = dividend_i[n-1];
`endif
                    end else begin
                        state_d     = DONE;
                        quotient_d  = divZeroQuo;
                        remainder_d = dividend_i;
                        divZero_d   = 1'b1;
                    end
                end
            end
            CALC: begin
                quo_d   = quoNext;
                rem_d   = remNext;
                count_d = count_q + 4'd1;
                if (count_q == 4'(n - 1)) begin
                    state_d = DONE;
`ifdef DIV_SIGNED_EN
                    quotient_d  = negQuo_q ? -quoNext : quoNext;
                    remainder_d = negRem_q ? -remNext : remNext;
`else
                    quotient_d  = quoNext;
                    remainder_d = remNext;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign quotient_o  = quotient_q;
    assign remainder_o = remainder_q;
    assign div_zero_o  = divZero_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed spec cases plus random operands against an arithmetic reference.
// Build with DIV_SIGNED_EN defined to exercise the two's-complement mode.

module tb_seq_divider;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_zero;

    int compared   = 0;
    int mismatched = 0;

    seq_divider #(.n(8)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .dividend_i  (dividend),
        .divisor_i   (divisor),
        .busy_o      (busy),
        .done_o      (done),
        .quotient_o  (quotient),
        .remainder_o (remainder),
        .div_zero_o  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference division straight from the arithmetic definition
    task automatic refDiv(input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] q, output logic [7:0] r, output logic dz);
`ifdef DIV_SIGNED_EN
        int sa, sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (b == 8'd0) begin
            q  = (sa >= 0) ? 8'hFF : 8'h01;
            r  = a;
            dz = 1'b1;
        end else begin
            q  = 8'(sa / sb);
            r  = 8'(sa % sb);
            dz = 1'b0;
        end
`else
        if (b == 8'd0) begin
            q  = 8'hFF;
            r  = a;
            dz = 1'b1;
        end else begin
            q  = 8'(int'(a) / int'(b));
            r  = 8'(int'(a) % int'(b));
            dz = 1'b0;
        end
`endif
    endtask

    // Issue one operation; optionally re-pulse start in a given cycle. Returns the cycle done appeared in.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input int disturbCycle, output int lat);
        @(posedge clk); #1;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (done) begin
                lat = cyc;
                break;
            end
            if (cyc == disturbCycle) begin
                start    = 1'b1;
                dividend = ~a;
                divisor  = 8'd0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic runOp(input string tag, input logic [7:0] a, input logic [7:0] b, input int disturbCycle);
        logic [7:0] q, r;
        logic       dz;
        int         lat;
        refDiv(a, b, q, r, dz);
        applyStimulus(a, b, disturbCycle, lat);
        checkOutput({tag, ".latency"}, 32'(lat), (b == 8'd0) ? 32'd1 : 32'd9);
        checkOutput({tag, ".quotient"}, 32'(quotient), 32'(q));
        checkOutput({tag, ".remainder"}, 32'(remainder), 32'(r));
        checkOutput({tag, ".div_zero"}, 32'(div_zero), 32'(dz));
        checkOutput({tag, ".busy"}, 32'(busy), 32'd1);
        @(posedge clk); #1;
        checkOutput({tag, ".done_pulse"}, 32'(done), 32'd0);
        checkOutput({tag, ".idle"}, 32'(busy), 32'd0);
        checkOutput({tag, ".hold"}, {16'd0, quotient, remainder}, {16'd0, q, r});
    endtask

    initial begin
        int lat;
        logic [7:0] ra, rb;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.busy", 32'(busy), 32'd0);
        checkOutput("reset.done", 32'(done), 32'd0);
        checkOutput("reset.results", {15'd0, div_zero, quotient, remainder}, 32'd0);
        rst_n = 1'b1;

        runOp("u100d7", 8'd100, 8'd7, 0);
        checkOutput("u100d7.q14", 32'(quotient), 32'h0E);
        checkOutput("u100d7.r2", 32'(remainder), 32'd2);
        runOp("u255d1", 8'd255, 8'd1, 0);
        checkOutput("u255d1.q", 32'(quotient), 32'd255);
        runOp("u3d200", 8'd3, 8'd200, 0);
        checkOutput("u3d200.qr", {16'd0, quotient, remainder}, 32'h0003);
        runOp("u200d200", 8'd200, 8'd200, 0);
        checkOutput("u200d200.qr", {16'd0, quotient, remainder}, 32'h0100);
        runOp("u5d0", 8'd5, 8'd0, 0);
        checkOutput("u5d0.fixed", {15'd0, div_zero, quotient, remainder}, 32'h1FF05);
        runOp("u9d3", 8'd9, 8'd3, 0);
        checkOutput("u9d3.fixed", {15'd0, div_zero, quotient, remainder}, 32'h00300);

        runOp("ignoreStart", 8'd100, 8'd7, 4);
        checkOutput("ignoreStart.fixed", {16'd0, quotient, remainder}, 32'h0E02);

        // Reset lands in cycle 5 of a calculation
        @(posedge clk); #1;
        start = 1'b1; dividend = 8'd77; divisor = 8'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checkOutput("midReset.busy", 32'(busy), 32'd0);
        checkOutput("midReset.done", 32'(done), 32'd0);
        checkOutput("midReset.results", {15'd0, div_zero, quotient, remainder}, 32'd0);
        runOp("u50d6", 8'd50, 8'd6, 0);
        checkOutput("u50d6.fixed", {16'd0, quotient, remainder}, 32'h0802);

`ifdef DIV_SIGNED_EN
        runOp("sN100d7", 8'h9C, 8'd7, 0);
        checkOutput("sN100d7.fixed", {16'd0, quotient, remainder}, 32'hF2FE);
        runOp("s100dN7", 8'd100, 8'hF9, 0);
        checkOutput("s100dN7.fixed", {16'd0, quotient, remainder}, 32'hF202);
        runOp("sN128dN1", 8'h80, 8'hFF, 0);
        checkOutput("sN128dN1.fixed", {16'd0, quotient, remainder}, 32'h8000);
        runOp("sN5d0", 8'hFB, 8'd0, 0);
        checkOutput("sN5d0.fixed", {15'd0, div_zero, quotient, remainder}, 32'h101FB);
`endif

        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom);
            rb = (i % 8 == 7) ? 8'd0 : 8'($urandom);
            runOp($sformatf("rand%0d", i), ra, rb, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
